// File: rtl/jk_excitation_sequencer_pkg.sv
// jk_pkg: sequencer state encoding and J/K excitation codes
package jk_pkg;
    typedef enum logic [2:0] {INIT, CHECK, IDLE, APPLY, VERIFY} jk_state_t;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;
endpackage

// File: rtl/jk_excitation_sequencer_if.sv
// jk_excitation_sequencer_if: valid/ready stream of target state words
interface jk_excitation_sequencer_if #(parameter int WIDTH = 4);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    modport master (output tgt_valid, output tgt_data, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excitation_sequencer_fifo.sv
// jk_tgt_fifo: synchronous target FIFO with wrap-bit pointers
module jk_tgt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];
    // pointer update; pushes on full and pops on empty are dropped
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    // storage needs no reset: entries are only read after being written
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/jk_excitation_sequencer.sv
// jk_excitation_sequencer: turns target words into J/K excitation for an external JK flip-flop bank
module jk_excitation_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int DEPTH         = 4,
    parameter bit PREFER_TOGGLE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jk_excitation_sequencer_if.slave tgt,
    output logic [WIDTH-1:0]         j,
    output logic [WIDTH-1:0]         k,
    input  logic [WIDTH-1:0]         q_fb,
    output logic                     busy,
    output logic                     step_done,
    output logic                     mismatch
);
    jk_state_t        state, state_nxt;
    logic [WIDTH-1:0] shadow, tgt_r, head, j_nxt, k_nxt, shadow_nxt, tgt_nxt;
    logic             init_go, go_nxt, step_nxt, mis_nxt, full, empty;

    function automatic logic [1:0] jk_code(input logic s, input logic t);
        return (s == t) ? JK_HOLD : PREFER_TOGGLE ? JK_TGL : t ? JK_SET : JK_RST;
    endfunction

    jk_tgt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tgt.tgt_valid),
        .din   (tgt.tgt_data),
        .pop   (state == IDLE),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign tgt.tgt_ready = !full;
    assign busy          = (state != IDLE) || !empty;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;

    // next state; INIT spends one cycle loading k=all-ones, then one cycle driving it
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = init_go ? CHECK : INIT;
            CHECK:   state_nxt = IDLE;
            IDLE:    state_nxt = empty ? IDLE : APPLY;
            APPLY:   state_nxt = VERIFY;
            VERIFY:  state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // next values of the registered outputs and the shadow/target copies
    always_comb begin
        j_nxt      = '0;
        k_nxt      = '0;
        go_nxt     = init_go;
        shadow_nxt = shadow;
        tgt_nxt    = tgt_r;
        step_nxt   = 1'b0;
        mis_nxt    = mismatch;
        case (state)
            INIT: begin
                go_nxt = 1'b1;
                k_nxt  = init_go ? '0 : '1;
            end
            CHECK: begin
                shadow_nxt = q_fb;
                mis_nxt    = mismatch | (q_fb != '0);
            end
            IDLE: if (!empty) begin
                tgt_nxt = head;
                for (int i = 0; i < WIDTH; i++) {j_nxt[i], k_nxt[i]} = jk_code(shadow[i], head[i]);
            end
            VERIFY: begin
                shadow_nxt = q_fb;
                step_nxt   = q_fb == tgt_r;
                mis_nxt    = mismatch | (q_fb != tgt_r);
            end
            default: ;
        endcase
    end

    // output and datapath registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            j         <= '0;
            k         <= '0;
            shadow    <= '0;
            tgt_r     <= '0;
            init_go   <= 1'b0;
            step_done <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            j         <= j_nxt;
            k         <= k_nxt;
            shadow    <= shadow_nxt;
            tgt_r     <= tgt_nxt;
            init_go   <= go_nxt;
            step_done <= step_nxt;
            mismatch  <= mis_nxt;
        end
endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// tb_jk_excitation_sequencer: two sequencers (set/reset and toggle encodings) each driving a modelled JK bank
module tb_jk_excitation_sequencer;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        logic [3:0] t;
        logic [3:0] j0;
        logic [3:0] k0;
        logic [3:0] j1;
        logic [3:0] k1;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, vld = 1'b0;
    logic [3:0] data = '0;
    logic [3:0] j0, k0, j1, k1;
    logic [3:0] q0 = 4'b1011, q1 = 4'b1011, stuck = '0;
    logic       busy0, busy1, sd0, sd1, mm0, mm1;
    int         tot = 0, bad = 0, acc = 0;
    bit         sb_on = 1'b0, saw_full = 1'b0;
    logic [3:0] exp_q [$];
    logic [3:0] last_acc = '0;
    vec_t       tv [6];

    always #5 clk = ~clk;

    jk_excitation_sequencer_if #(.WIDTH(W)) if0 ();
    jk_excitation_sequencer_if #(.WIDTH(W)) if1 ();
    assign if0.tgt_valid = vld;
    assign if0.tgt_data  = data;
    assign if1.tgt_valid = vld;
    assign if1.tgt_data  = data;

    jk_excitation_sequencer #(.WIDTH(W), .DEPTH(D), .PREFER_TOGGLE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt(if0), .j(j0), .k(k0), .q_fb(q0),
        .busy(busy0), .step_done(sd0), .mismatch(mm0)
    );
    jk_excitation_sequencer #(.WIDTH(W), .DEPTH(D), .PREFER_TOGGLE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt(if1), .j(j1), .k(k1), .q_fb(q1),
        .busy(busy1), .step_done(sd1), .mismatch(mm1)
    );

    // JK characteristic equation: Q+ = J&~Q | ~K&Q
    function automatic logic [3:0] jk_ff(input logic [3:0] q, input logic [3:0] jj, input logic [3:0] kk);
        return (jj & ~q) | (~kk & q);
    endfunction

    // expected {j,k} for moving the bank from s to t
    function automatic logic [7:0] excite(input logic [3:0] s, input logic [3:0] t, input bit tog);
        logic [3:0] d;
        d = s ^ t;
        return tog ? {d, d} : {t & ~s, s & ~t};
    endfunction

    always @(posedge clk) begin
        q0 <= jk_ff(q0, j0, k0) & ~stuck;
        q1 <= jk_ff(q1, j1, k1) & ~stuck;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tot++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", {busy0, busy1}, 2'b00);
    endtask

    // scoreboard: accepted words must be applied in order with the right J/K, then verified
    always @(posedge clk) begin : mon
        bit         hs;
        logic [3:0] hd, w;
        hs = sb_on && vld && if0.tgt_ready;
        hd = data;
        #1;
        if (sb_on) begin
            if (hs) begin
                exp_q.push_back(hd);
                acc++;
                last_acc = hd;
            end
            if (!if0.tgt_ready || !if1.tgt_ready) begin
                saw_full = 1'b1;
                tot++;
                if (exp_q.size() < D) begin
                    bad++;
                    $display("FAIL ready_low act=ready0:%0b,ready1:%0b outstanding=%0d exp=outstanding>=%0d", if0.tgt_ready, if1.tgt_ready, exp_q.size(), D);
                end
            end
            if ({j0, k0, j1, k1} != '0) begin
                if (exp_q.size() == 0) begin
                    tot++;
                    bad++;
                    $display("FAIL jk_no_target act=%0h exp=0", {j0, k0, j1, k1});
                end else begin
                    chk("sb_jk0", {j0, k0}, excite(q0, exp_q[0], 1'b0));
                    chk("sb_jk1", {j1, k1}, excite(q1, exp_q[0], 1'b1));
                end
            end
            if (sd0 || sd1) begin
                if (exp_q.size() == 0) begin
                    tot++;
                    bad++;
                    $display("FAIL step_no_target act=%0b%0b exp=00", sd0, sd1);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_sd_pair", {sd0, sd1}, 2'b11);
                    chk("sb_q", {q0, q1}, {w, w});
                end
            end
            chk("sb_mismatch", {mm0, mm1}, 2'b00);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010};
        tv[1] = '{4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100};
        tv[2] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tv[3] = '{4'b1001, 4'b1001, 4'b0110, 4'b1111, 4'b1111};
        tv[4] = '{4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1001};
        tv[5] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111};

        // reset and INIT forcing of the bank
        tick();
        tick();
        chk("rst_jk", {j0, k0, j1, k1}, 16'h0000);
        chk("rst_flags", {sd0, mm0, sd1, mm1}, 4'b0000);
        chk("rst_busy", {busy0, busy1}, 2'b11);
        chk("rst_ready", {if0.tgt_ready, if1.tgt_ready}, 2'b11);
        rst_n = 1'b1;
        tick();
        chk("init_jk0", {j0, k0}, 8'h0F);
        chk("init_jk1", {j1, k1}, 8'h0F);
        tick();
        chk("init_release_jk", {j0, k0, j1, k1}, 16'h0000);
        chk("init_bank", {q0, q1}, 8'h00);
        tick();
        chk("init_idle", {busy0, busy1, mm0, mm1}, 4'b0000);

        // single steps with fixed latency
        for (int i = 0; i < 6; i++) begin
            vld = 1'b1;
            data = tv[i].t;
            tick();
            vld = 1'b0;
            tick();
            chk("tbl_jk0", {j0, k0}, {tv[i].j0, tv[i].k0});
            chk("tbl_jk1", {j1, k1}, {tv[i].j1, tv[i].k1});
            tick();
            chk("tbl_q", {q0, q1}, {tv[i].t, tv[i].t});
            chk("tbl_sd_early", {sd0, sd1}, 2'b00);
            tick();
            chk("tbl_sd", {sd0, sd1}, 2'b11);
            chk("tbl_jk_after", {j0, k0, j1, k1}, 16'h0000);
            chk("tbl_mm", {mm0, mm1}, 2'b00);
        end

        // back-to-back offers until the FIFO fills
        exp_q.delete();
        acc = 0;
        saw_full = 1'b0;
        sb_on = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vld = 1'b1;
            data = i[3:0];
            tick();
        end
        vld = 1'b0;
        chk("full_accepted", acc, 6);
        chk("full_seen", saw_full, 1'b1);
        wait_idle();
        chk("full_drain", exp_q.size(), 0);
        chk("full_last", {q0, q1}, 8'h66);

        // random traffic against the scoreboard
        for (int c = 0; c < 300; c++) begin
            vld = $urandom_range(0, 3) != 0;
            data = 4'($urandom);
            tick();
        end
        vld = 1'b0;
        wait_idle();
        chk("rnd_drain", exp_q.size(), 0);
        chk("rnd_last", {q0, q1}, {last_acc, last_acc});
        sb_on = 1'b0;

        // bank bit 1 stuck at 0
        stuck = 4'b0010;
        vld = 1'b1;
        data = 4'b1111;
        tick();
        vld = 1'b0;
        tick();
        tick();
        chk("stuck_q", {q0, q1}, 8'hDD);
        tick();
        chk("stuck_mm", {mm0, mm1}, 2'b11);
        chk("stuck_no_sd", {sd0, sd1}, 2'b00);
        vld = 1'b1;
        data = 4'b0000;
        tick();
        vld = 1'b0;
        tick();
        chk("resync_jk0", {j0, k0}, 8'h0D);
        chk("resync_jk1", {j1, k1}, 8'hDD);
        tick();
        tick();
        chk("resync_sd", {sd0, sd1}, 2'b11);
        chk("mm_sticky", {mm0, mm1}, 2'b11);
        chk("resync_q", {q0, q1}, 8'h00);
        stuck = 4'b0000;

        // reset during APPLY with words queued
        for (int i = 0; i < 5; i++) begin
            vld = 1'b1;
            case (i)
                0: data = 4'b1111;
                1: data = 4'b0101;
                2: data = 4'b0011;
                3: data = 4'b1100;
                default: data = 4'b1000;
            endcase
            tick();
        end
        vld = 1'b0;
        chk("mid_apply_jk0", {j0, k0}, 8'h0A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_jk", {j0, k0, j1, k1}, 16'h0000);
        chk("mid_rst_ready", {if0.tgt_ready, if1.tgt_ready}, 2'b11);
        chk("mid_rst_flags", {sd0, mm0, sd1, mm1}, 4'b0000);
        chk("mid_rst_busy", {busy0, busy1}, 2'b11);
        tick();
        chk("mid_rst_bank_held", {q0, q1}, 8'hFF);
        rst_n = 1'b1;
        tick();
        chk("reinit_k", {k0, k1}, 8'hFF);
        tick();
        chk("reinit_bank", {q0, q1}, 8'h00);
        tick();
        chk("reinit_idle", {busy0, busy1}, 2'b00);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lost_queue_quiet", {j0, k0, j1, k1, q0, q1}, 24'h0);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
